controle_multiciclo: RTL and testbench

Multicycle control unit for the MIPS-subset datapath. It is a Moore state machine that decodes the instruction opcode and, cycle by cycle, drives every datapath select and enable: RegDst, ALUSrc A/B, MemToReg, PC source, the register/memory/IR write strobes and the ALU operation class. It sits between the instruction register and the datapath muxes, PC, register bank and ALU control. It waits on a memory-ready handshake for every memory access.

---
 rtl/controle_multiciclo.sv | 134 +++++++++++++
 tb/tb_controle_multiciclo.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/controle_multiciclo.sv
// Multicycle MIPS-subset control unit: Moore FSM that sequences fetch, decode,
// execute, memory and writeback, stalling on the memory-ready handshake.
module controle_multiciclo (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [5:0] i_opcode,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_pc_en,
  output logic       o_iord,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_ir_write,
  output logic       o_reg_dst,
  output logic       o_mem_to_reg,
  output logic       o_reg_write,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_alu_op,
  output logic [1:0] o_pc_source,
  output logic       o_excecao,
  output logic [3:0] o_estado
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3,
    S_MEMREAD = 4'd4, S_MEMWB = 4'd5, S_MEMWRITE = 4'd6, S_EXECUTE = 4'd7,
    S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
    S_JUMP = 4'd12, S_ILLEGAL = 4'd13
  } state_t;

  typedef struct packed {
    logic       fetch;
    logic       pc_write;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       excecao;
  } ctrl_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t r_state;
  state_t w_next;
  ctrl_t  r_ctrl;

  // Outputs are registered from the next state, so they are a pure decode of r_state.
  function automatic ctrl_t f_decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.fetch = 1'b1; c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
      S_DECODE:   c.alu_src_b = 2'b11;
      S_MEMADR:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEMREAD:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
      S_MEMWB:    begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      S_MEMWRITE: begin c.mem_write = 1'b1; c.iord = 1'b1; end
      S_EXECUTE:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      S_ALUWB:    begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      S_BRANCH:   begin
        c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_source = 2'b01; c.branch = 1'b1;
      end
      S_ADDIEX:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_ADDIWB:   c.reg_write = 1'b1;
      S_JUMP:     begin c.pc_source = 2'b10; c.pc_write = 1'b1; end
      S_ILLEGAL:  c.excecao = 1'b1;
      default:    c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_IDLE:     w_next = S_FETCH;
      S_FETCH:    w_next = i_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:
        case (i_opcode)
          OP_R:          w_next = S_EXECUTE;
          OP_LW, OP_SW:  w_next = S_MEMADR;
          OP_BEQ:        w_next = S_BRANCH;
          OP_ADDI:       w_next = S_ADDIEX;
          OP_J:          w_next = S_JUMP;
          default:       w_next = S_ILLEGAL;
        endcase
      S_MEMADR:   w_next = (i_opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next = i_mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: w_next = i_mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  w_next = S_ALUWB;
      S_ADDIEX:   w_next = S_ADDIWB;
      default:    w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= f_decode(w_next);
    end
  end

  // The fetch strobes fire only in the MemReady cycle: one IR load and one PC+4 per fetch.
  assign o_ir_write   = r_ctrl.fetch & i_mem_ready;
  assign o_pc_en      = (r_ctrl.fetch & i_mem_ready) | r_ctrl.pc_write | (r_ctrl.branch & i_zero);
  assign o_iord       = r_ctrl.iord;
  assign o_mem_read   = r_ctrl.mem_read;
  assign o_mem_write  = r_ctrl.mem_write;
  assign o_reg_dst    = r_ctrl.reg_dst;
  assign o_mem_to_reg = r_ctrl.mem_to_reg;
  assign o_reg_write  = r_ctrl.reg_write;
  assign o_alu_src_a  = r_ctrl.alu_src_a;
  assign o_alu_src_b  = r_ctrl.alu_src_b;
  assign o_alu_op     = r_ctrl.alu_op;
  assign o_pc_source  = r_ctrl.pc_source;
  assign o_excecao    = r_ctrl.excecao;
  assign o_estado     = r_state;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Scoreboard bench for controle_multiciclo: expected per-cycle state/strobe
// records are queued as stimulus is applied and checked on the falling edge.
module tb_controle_multiciclo;

  typedef struct packed {
    logic [3:0] st;
    logic       pcen, iord, mrd, mwr, irw, rdst, m2r, rwr, srca;
    logic [1:0] srcb, aluop, pcsrc;
    logic       exc;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, excecao;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] estado;

  int   n_vec = 0;
  int   n_err = 0;
  rec_t sb[$];

  always #5 clk = ~clk;

  controle_multiciclo dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode), .i_zero(zero),
    .i_mem_ready(mem_ready), .o_pc_en(pc_en), .o_iord(iord), .o_mem_read(mem_read),
    .o_mem_write(mem_write), .o_ir_write(ir_write), .o_reg_dst(reg_dst),
    .o_mem_to_reg(mem_to_reg), .o_reg_write(reg_write), .o_alu_src_a(alu_src_a),
    .o_alu_src_b(alu_src_b), .o_alu_op(alu_op), .o_pc_source(pc_source),
    .o_excecao(excecao), .o_estado(estado)
  );

  // Expected outputs per state, written from the control table.
  function automatic rec_t exp_of(input logic [3:0] s, input logic z, input logic mr);
    rec_t r;
    r = '0;
    r.st = s;
    case (s)
      4'd1:  begin r.mrd = 1; r.srcb = 2'b01; r.irw = mr; r.pcen = mr; end
      4'd2:  r.srcb = 2'b11;
      4'd3:  begin r.srca = 1; r.srcb = 2'b10; end
      4'd4:  begin r.mrd = 1; r.iord = 1; end
      4'd5:  begin r.m2r = 1; r.rwr = 1; end
      4'd6:  begin r.mwr = 1; r.iord = 1; end
      4'd7:  begin r.srca = 1; r.aluop = 2'b10; end
      4'd8:  begin r.rdst = 1; r.rwr = 1; end
      4'd9:  begin r.srca = 1; r.aluop = 2'b01; r.pcsrc = 2'b01; r.pcen = z; end
      4'd10: begin r.srca = 1; r.srcb = 2'b10; end
      4'd11: r.rwr = 1;
      4'd12: begin r.pcsrc = 2'b10; r.pcen = 1; end
      4'd13: r.exc = 1;
      default: r = r;
    endcase
    return r;
  endfunction

  function automatic rec_t actual();
    rec_t a;
    a = {estado, pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
         reg_write, alu_src_a, alu_src_b, alu_op, pc_source, excecao};
    return a;
  endfunction

  // Called at posedge+1: drive one cycle of inputs, check at the falling edge.
  task automatic step(input logic [5:0] op, input logic z, input logic mr,
                      input logic [3:0] st, input string tag);
    rec_t e, a;
    opcode = op; zero = z; mem_ready = mr;
    sb.push_back(exp_of(st, z, mr));
    @(negedge clk);
    e = sb.pop_front();
    a = actual();
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got st=%0d rec=%h, want st=%0d rec=%h", tag, a.st, a, e.st, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) step(6'd0, 1'b1, 1'b1, 4'd0, "reset_hold");
    rst_n = 1'b1;
    step(6'd0, 1'b1, 1'b1, 4'd0, "reset_release_idle");
  endtask

  task automatic test_rtype();
    step(6'b000000, 0, 1, 4'd1, "r_fetch");
    step(6'b000000, 0, 1, 4'd2, "r_decode");
    step(6'b000000, 0, 1, 4'd7, "r_execute");
    step(6'b000000, 0, 1, 4'd8, "r_aluwb");
  endtask

  task automatic test_lw_wait();
    step(6'b100011, 0, 1, 4'd1, "lw_fetch");
    step(6'b100011, 0, 1, 4'd2, "lw_decode");
    step(6'b100011, 0, 1, 4'd3, "lw_memadr");
    step(6'b100011, 0, 0, 4'd4, "lw_memread_wait0");
    step(6'b100011, 0, 0, 4'd4, "lw_memread_wait1");
    step(6'b100011, 0, 1, 4'd4, "lw_memread_done");
    step(6'b100011, 0, 1, 4'd5, "lw_memwb");
  endtask

  task automatic test_sw();
    step(6'b101011, 0, 1, 4'd1, "sw_fetch");
    step(6'b101011, 0, 1, 4'd2, "sw_decode");
    step(6'b101011, 0, 1, 4'd3, "sw_memadr");
    step(6'b101011, 0, 1, 4'd6, "sw_memwrite");
  endtask

  task automatic test_beq();
    step(6'b000100, 1, 1, 4'd1, "beq_t_fetch");
    step(6'b000100, 1, 1, 4'd2, "beq_t_decode");
    step(6'b000100, 1, 1, 4'd9, "beq_taken");
    step(6'b000100, 0, 1, 4'd1, "beq_n_fetch");
    step(6'b000100, 0, 1, 4'd2, "beq_n_decode");
    step(6'b000100, 0, 1, 4'd9, "beq_not_taken");
  endtask

  task automatic test_fetch_wait_jump();
    for (int i = 0; i < 3; i++) step(6'b000010, 0, 0, 4'd1, "fetch_wait");
    step(6'b000010, 0, 1, 4'd1, "fetch_ready");
    step(6'b000010, 0, 1, 4'd2, "j_decode");
    step(6'b000010, 0, 1, 4'd12, "j_jump");
  endtask

  task automatic test_illegal_addi();
    step(6'b111111, 0, 1, 4'd1, "ill_fetch");
    step(6'b111111, 0, 1, 4'd2, "ill_decode");
    step(6'b111111, 0, 1, 4'd13, "ill_exc");
    step(6'b001000, 0, 1, 4'd1, "addi_fetch");
    step(6'b001000, 0, 1, 4'd2, "addi_decode");
    step(6'b001000, 0, 1, 4'd10, "addi_ex");
    step(6'b001000, 0, 1, 4'd11, "addi_wb");
  endtask

  task automatic test_reset_mid_write();
    rec_t e, a;
    step(6'b101011, 0, 1, 4'd1, "rst_sw_fetch");
    step(6'b101011, 0, 1, 4'd2, "rst_sw_decode");
    step(6'b101011, 0, 1, 4'd3, "rst_sw_memadr");
    step(6'b101011, 0, 0, 4'd6, "rst_sw_memwrite_wait");
    // Still in MEMWRITE here; pull reset between clock edges.
    rst_n = 1'b0;
    sb.push_back(exp_of(4'd0, 0, 0));
    #1;
    e = sb.pop_front();
    a = actual();
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL async_reset_midwrite: got st=%0d mwr=%b, want st=%0d mwr=%b",
               a.st, a.mwr, e.st, e.mwr);
    end
    @(posedge clk); #1;
    step(6'b101011, 0, 1, 4'd0, "rst_mid_hold");
    rst_n = 1'b1;
    step(6'b101011, 0, 1, 4'd0, "rst_mid_idle");
    step(6'b000000, 0, 1, 4'd1, "rst_mid_fetch");
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw();
    test_beq();
    test_fetch_wait_jump();
    test_illegal_addi();
    test_reset_mid_write();
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
